// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive controller: FSM states,
// legal oversampling ratios and the mid-bit decision edge.
package uart_rx_pkg;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  // First edge after the sampler's three-edge majority vote has settled.
  function automatic logic [5:0] chk_edge(input logic [5:0] p);
    return (p >> 1) + 6'd2;
  endfunction

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (0..P-1) and data bit counter (0..DATA_WIDTH-1)
// for the UART receive controller.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_bit_en,
  input  logic [5:0]    i_prescale,
  output logic [5:0]    o_edge_cnt,
  output logic [BW-1:0] o_bit_cnt,
  output logic          o_wrap
);

  logic [5:0]    r_edge_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          w_wrap;

  assign w_wrap = i_en && (r_edge_cnt == (i_prescale - 6'd1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clr) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_en) begin
      r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;
      if (w_wrap && i_bit_en)
        r_bit_cnt <= (r_bit_cnt == BW'(DATA_WIDTH - 1)) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_wrap     = w_wrap;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, per-bit timing, checker and
// deserializer enables at the mid-bit point, and frame good/error pulses.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic [5:0] edge_cnt,
  output logic       data_valid,
  output logic       frame_err
);

  rx_state_e     r_state;
  logic [5:0]    r_prescale;
  logic          r_par_en;
  logic          r_err;
  logic          r_data_valid;
  logic          r_frame_err;

  logic          w_active;
  logic          w_at_chk;
  logic          w_clr;
  logic          w_wrap;
  logic          w_last_bit;
  logic [5:0]    w_edge_cnt;
  logic [BW-1:0] w_bit_cnt;

  assign w_active = (r_state == ST_START) || (r_state == ST_DATA) ||
                    (r_state == ST_PARITY) || (r_state == ST_STOP);
  assign w_at_chk   = (w_edge_cnt == chk_edge(r_prescale));
  assign w_last_bit = (w_bit_cnt == BW'(DATA_WIDTH - 1));

  // Counters restart on every exit from the bit-timed states, including an
  // aborted start and the early exit from the stop bit.
  assign w_clr = !w_active ||
                 ((r_state == ST_START) && w_at_chk && !strt_glitch) ||
                 ((r_state == ST_STOP) && w_at_chk);

  uart_rx_edge_bit_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_en       (w_active),
    .i_clr      (w_clr),
    .i_bit_en   (r_state == ST_DATA),
    .i_prescale (r_prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_prescale   <= PRESCALE_8;
      r_par_en     <= 1'b0;
      r_err        <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!RX_IN) begin
            r_state    <= ST_START;
            r_prescale <= legal_prescale(Prescale);
            r_par_en   <= PAR_EN;
          end
        end
        ST_START: begin
          if (w_at_chk && !strt_glitch) r_state <= ST_IDLE;
          else if (w_wrap)              r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_wrap && w_last_bit) r_state <= r_par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (w_at_chk && par_err) r_err <= 1'b1;
          if (w_wrap) r_state <= ST_STOP;
        end
        ST_STOP: begin
          // Verdict registers together with the DONE entry so both pulses
          // align with the DONE cycle.
          if (w_at_chk) begin
            r_state      <= ST_DONE;
            r_data_valid <= !(r_err || stp_err);
            r_frame_err  <= r_err || stp_err;
          end
        end
        ST_DONE: begin
          r_err <= 1'b0;
          if (!RX_IN) begin
            r_state    <= ST_START;
            r_prescale <= legal_prescale(Prescale);
            r_par_en   <= PAR_EN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dat_samp_en = w_active;
  assign strt_chk_en = (r_state == ST_START)  && w_at_chk;
  assign deser_en    = (r_state == ST_DATA)   && w_at_chk;
  assign par_chk_en  = (r_state == ST_PARITY) && w_at_chk;
  assign stp_chk_en  = (r_state == ST_STOP)   && w_at_chk;
  assign edge_cnt    = w_edge_cnt;
  assign data_valid  = r_data_valid;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: per-cycle comparison of all outputs
// against expected frame timing derived from prescale, parity and check edge.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
  logic [5:0] edge_cnt;
  logic       data_valid, frame_err;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .edge_cnt    (edge_cnt),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  always #5 CLK = ~CLK;

  // {dat_samp_en, strt, par, stp, deser, edge_cnt[5:0], data_valid, frame_err}
  logic [12:0] w_obs;
  assign w_obs = {dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
                  edge_cnt, data_valid, frame_err};

  int n_assert = 0;
  int n_fail   = 0;
  int n_deser = 0, n_dv = 0, n_fe = 0, n_par = 0;
  int s_deser, s_dv, s_fe, s_par;
  logic [12:0] exp_cur;

  always @(posedge CLK) begin
    if (deser_en)   n_deser++;
    if (data_valid) n_dv++;
    if (frame_err)  n_fe++;
    if (par_chk_en) n_par++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag, input logic [12:0] exp);
    @(negedge CLK);
    check(tag, {19'd0, w_obs}, {19'd0, exp});
    @(posedge CLK);
    #1;
  endtask

  function automatic int eff_p(input logic [5:0] presc);
    return (presc == 6'd16 || presc == 6'd32) ? int'(presc) : 8;
  endfunction

  // Serial line level at 'rel' cycles after the first low sample.
  function automatic logic line_bit(input int rel, input int p, input logic [7:0] data,
                                    input bit pe, input bit glitch);
    int idx;
    if (glitch) return (rel < 2) ? 1'b0 : 1'b1;
    idx = rel / p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    if (pe && idx == 9) return ^data;
    return 1'b1;
  endfunction

  // Expected outputs at START-relative cycle r (0 = START edge 0) while bit-timed.
  function automatic logic [12:0] exp_vec(input int r, input int p, input int chk,
                                          input int rs, input bit pe);
    logic [5:0] e;
    bit st, pc, sc, de;
    e  = 6'(r % p);
    st = (r == chk);
    de = (r >= p) && (r < 9 * p) && ((r % p) == chk);
    pc = pe && (r == 9 * p + chk);
    sc = (r == rs);
    return {1'b1, st, pc, sc, de, e, 2'b00};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      RX_IN = 1'b1;
      Prescale = 6'($urandom);
      PAR_EN = 1'($urandom);
      strt_glitch = 1'($urandom);
      par_err = 1'($urandom);
      stp_err = 1'($urandom);
      sample("idle", exp_cur);
      exp_cur = '0;
    end
  endtask

  // Runs one frame from the first-low cycle t; leaves exp_cur holding the
  // expectation for the following cycle (DONE or IDLE).
  task automatic play_frame(input string tag, input logic [5:0] presc, input bit pe,
                            input bit perr, input bit serr, input bit glitch,
                            input logic [7:0] data, input int abort_r);
    int p, chk, rs, last;
    bit err;
    p    = eff_p(presc);
    chk  = p / 2 + 2;
    rs   = p * (9 + (pe ? 1 : 0)) + chk;
    last = glitch ? chk : rs;
    err  = serr || (pe && perr);

    RX_IN = 1'b0;
    Prescale = presc;
    PAR_EN = pe;
    strt_glitch = 1'($urandom);
    par_err = 1'($urandom);
    stp_err = 1'($urandom);
    sample({tag, "_t"}, exp_cur);

    for (int r = 0; r <= last; r++) begin
      RX_IN = line_bit(r + 1, p, data, pe, glitch);
      Prescale = 6'($urandom);
      PAR_EN = 1'($urandom);
      strt_glitch = (r == chk) ? !glitch : 1'($urandom);
      par_err = (r == 9 * p + chk) ? perr : 1'($urandom);
      stp_err = (r == rs) ? serr : 1'($urandom);
      if (r == abort_r) begin
        RST = 1'b0;
        #1;
        check({tag, "_rst"}, {19'd0, w_obs}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_cur = '0;
        return;
      end
      sample(tag, exp_vec(r, p, chk, rs, pe));
    end
    exp_cur = glitch ? 13'd0 : {11'd0, !err, err};
  endtask

  task automatic snap();
    s_deser = n_deser; s_dv = n_dv; s_fe = n_fe; s_par = n_par;
  endtask

  initial begin
    logic [5:0] presc;
    bit pe, perr, serr, glitch, chain;

    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
    strt_glitch = 1'b1; par_err = 1'b0; stp_err = 1'b0;
    exp_cur = '0;
    #12;
    check("reset", {19'd0, w_obs}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(3);

    // P=8, no parity, 0xA5
    snap();
    play_frame("p8", 6'd8, 0, 0, 0, 0, 8'hA5, -1);
    idle(2);
    check("p8_deser_cnt", n_deser - s_deser, 8);
    check("p8_dv_cnt", n_dv - s_dv, 1);
    check("p8_fe_cnt", n_fe - s_fe, 0);

    // P=16 with parity error
    snap();
    play_frame("p16_perr", 6'd16, 1, 1, 0, 0, 8'h3C, -1);
    idle(2);
    check("perr_parchk_cnt", n_par - s_par, 1);
    check("perr_fe_cnt", n_fe - s_fe, 1);
    check("perr_dv_cnt", n_dv - s_dv, 0);

    // Parity and stop errors in one frame
    snap();
    play_frame("p8_both_err", 6'd8, 1, 1, 1, 0, 8'h81, -1);
    idle(2);
    check("both_fe_cnt", n_fe - s_fe, 1);
    check("both_dv_cnt", n_dv - s_dv, 0);

    // Start glitch
    snap();
    play_frame("glitch", 6'd8, 0, 0, 0, 1, 8'h00, -1);
    idle(2);
    check("glitch_deser_cnt", n_deser - s_deser, 0);
    check("glitch_dv_cnt", n_dv - s_dv, 0);
    check("glitch_fe_cnt", n_fe - s_fe, 0);

    // Back-to-back P=32 frames
    snap();
    play_frame("p32_a", 6'd32, 0, 0, 0, 0, 8'h5A, -1);
    play_frame("p32_b", 6'd32, 1, 0, 0, 0, 8'hC3, -1);
    idle(2);
    check("b2b_dv_cnt", n_dv - s_dv, 2);

    // Illegal prescale behaves as 8
    play_frame("presc12", 6'd12, 0, 0, 0, 0, 8'h96, -1);
    idle(2);

    // Reset during DATA bit 4, then a clean frame
    play_frame("rst_mid", 6'd8, 0, 0, 0, 0, 8'hF0, 8 * 5 + 3);
    idle(2);
    snap();
    play_frame("after_rst", 6'd8, 0, 0, 0, 0, 8'h0F, -1);
    idle(2);
    check("after_rst_dv_cnt", n_dv - s_dv, 1);

    // Randomised frames
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: presc = 6'd8;
        1: presc = 6'd16;
        2: presc = 6'd32;
        default: begin
          presc = 6'($urandom);
          if (presc == 6'd8 || presc == 6'd16 || presc == 6'd32) presc = 6'd5;
        end
      endcase
      pe     = 1'($urandom);
      perr   = ($urandom_range(0, 3) == 0);
      serr   = ($urandom_range(0, 3) == 0);
      glitch = ($urandom_range(0, 5) == 0);
      chain  = !glitch && 1'($urandom);
      play_frame("rand", presc, pe, perr, serr, glitch, 8'($urandom), -1);
      if (!chain) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. It detects the falling edge that opens a frame and tracks position inside each bit with an edge/bit counter. It pulses the enables for the start, parity and stop checkers and the deserializer at the mid-bit decision point. It raises `data_valid` only for frames that pass every check. It sits between the oversampling data sampler and the per-field checker and deserializer blocks.

## Interface
- `DATA_WIDTH`, 8, data bits per frame.
- `CLK` in 1: receiver oversampling clock.
- `RST` in 1: asynchronous, active-low reset.
- `RX_IN` in 1: serial line (idle high), already synchronised.
- `Prescale` in 6: oversampling ratio. Legal values are 8, 16 and 32; any other value is treated as 8.
- `PAR_EN` in 1: parity bit present.
- `strt_glitch` in 1: start-checker result. 1 = start bit confirmed low; 0 = glitch.
- `par_err` in 1: parity-checker result. 1 = error.
- `stp_err` in 1: stop-checker result. 1 = error.
- `dat_samp_en` out 1: enables the data sampler.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en` out 1 each: checker enables.
- `deser_en` out 1: shifts the sampled bit into the deserializer.
- `edge_cnt` out 6: oversample index inside the current bit.
- `data_valid` out 1: one-cycle pulse, frame good.
- `frame_err` out 1: one-cycle pulse, frame rejected on a parity or stop error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. Reset state is IDLE.
- `Prescale` (P) and `PAR_EN` are latched on the IDLE→START transition. Changes made mid-frame take effect on the next frame.
- Define CHK = P/2+2, the first edge at which the majority-sampled bit is stable. The sampler votes on edges P/2-1, P/2 and P/2+1.
- `edge_cnt` runs 0..P-1 in every non-IDLE, non-DONE state and wraps to 0. `bit_cnt` (internal, 0..DATA_WIDTH-1) increments on each wrap while in DATA.
- Transitions:
  - IDLE→START when `RX_IN`=0.
  - START: `strt_chk_en` is high at edge CHK. If `strt_glitch`=0 in that cycle, go to IDLE. Otherwise go to DATA at the wrap after edge P-1.
  - DATA: `deser_en` is high at edge CHK of each bit. At the wrap after bit DATA_WIDTH-1, go to PARITY if the latched `PAR_EN` is 1, else STOP.
  - PARITY: `par_chk_en` is high at edge CHK. If `par_err`=1, set the sticky error flag. Go to STOP at the wrap.
  - STOP: `stp_chk_en` is high at edge CHK. If `stp_err`=1, set the sticky error flag. Go to DONE in the cycle after CHK; the controller does not wait for the end of the stop bit, so back-to-back frames are accepted.
  - DONE: lasts one cycle. `data_valid`=!err and `frame_err`=err. The error flag clears. Go to START if `RX_IN`=0, else IDLE.
- `dat_samp_en`=1 in START, DATA, PARITY and STOP.
- Check and `deser_en` enables are decoded combinationally from state and `edge_cnt`. `data_valid` and `frame_err` are registered.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, error flag clear. Reset acts immediately at any point in a frame.
- If `RX_IN` is first sampled low in cycle t, START edge 0 is cycle t+1.
- P=8, no parity: `data_valid` is high in cycle t+80. With parity it is t+88. Generally the pulse lands at t+P·(DATA_WIDTH+1+PAR_EN)+CHK+2.
- When a glitch is detected at START edge CHK, the state is IDLE in the next cycle and no `deser_en` pulse has fired.
- Parity and stop errors arriving in the same frame still give exactly one `frame_err` pulse.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum `rx_state_e`;
  - the legal prescale constants;
  - function `chk_edge(P)`, which returns P/2+2.
- Sub-module `uart_rx_edge_bit_cnt` implements the edge and bit counters. It takes enable, latched P and state-clear inputs and produces `edge_cnt`, `bit_cnt` and a wrap strobe.

## Test plan
- P=8, no parity, frame 0xA5 with the start bit low at cycle t. Required: 8 `deser_en` pulses at START-relative cycles 14,22,…,70; `data_valid`=1 at t+80; `frame_err`=0.
- P=16, parity on, `par_err` forced to 1. Required: `par_chk_en` pulses once; `frame_err` pulses once; no `data_valid`.
- P=8, `RX_IN` low for 2 cycles then high (`strt_glitch`=0 at CHK). Required: IDLE at the next cycle; `deser_en`, `data_valid` and `frame_err` all stay 0.
- Two P=32 frames with no idle gap between them. Required: two `data_valid` pulses, DONE→START with no IDLE cycle between.
- `Prescale`=12. Required: timing identical to P=8. Separately, `Prescale` changed mid-frame: the current frame keeps the old ratio.
- `RST` asserted during DATA bit 4. Required: all outputs 0 immediately; the next frame is received correctly.
